// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for a small MIPS subset (addu/subu/ori/lui/lw/sw/beq/j/nop).
// Only the state register is stored; every control output is decoded from state, instr, branch and mem_ready.
module mc_ctrl #(
  parameter int ALU_OP_W = 4,
  parameter int CMP_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                branch,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_addr_sel,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_sel,
  output logic                reg_we,
  output logic                reg_dst,
  output logic                wd_sel,
  output logic                alu_src_b,
  output logic                ext_op,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [CMP_OP_W-1:0] cmp_op,
  output logic                instr_done,
  output logic                illegal
);

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_LUI = ALU_OP_W'(3);
  localparam logic [CMP_OP_W-1:0] CMP_BEQ = CMP_OP_W'(1);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [5:0] op;
  logic [5:0] funct;
  logic is_nop, is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j;
  logic is_legal_ex;

  assign op      = instr[31:26];
  assign funct   = instr[5:0];
  assign is_nop  = (instr == 32'h0);
  assign is_addu = (op == 6'h00) && (funct == 6'h21);
  assign is_subu = (op == 6'h00) && (funct == 6'h23);
  assign is_ori  = (op == 6'h0D);
  assign is_lui  = (op == 6'h0F);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
  assign is_j    = (op == 6'h02);
  assign is_legal_ex = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq;

  // ALU controls decoded once so EX, MEM and WB present identical values
  logic [ALU_OP_W-1:0] ex_alu_op;
  logic                ex_alu_src_b;
  logic                ex_ext_op;

  always_comb begin
    ex_alu_op = ALU_ADD;
    if (is_subu)     ex_alu_op = ALU_SUB;
    else if (is_ori) ex_alu_op = ALU_OR;
    else if (is_lui) ex_alu_op = ALU_LUI;
  end

  assign ex_alu_src_b = is_ori | is_lui | is_lw | is_sw;
  assign ex_ext_op    = is_lw | is_sw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    reg_we       = 1'b0;
    reg_dst      = 1'b0;
    wd_sel       = 1'b0;
    alu_src_b    = 1'b0;
    ext_op       = 1'b0;
    alu_op       = ALU_ADD;
    cmp_op       = '0;
    instr_done   = 1'b0;
    illegal      = 1'b0;

    // Outputs stay zero while reset is held, independent of the clock
    if (rst_n) begin
      case (state_q)
        S_IF: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_ID;
          end
        end
        S_ID: begin
          state_d = S_IF;
          if (is_j) begin
            pc_we      = 1'b1;
            pc_sel     = 2'd2;
            instr_done = 1'b1;
          end else if (is_nop) begin
            instr_done = 1'b1;
          end else if (is_legal_ex) begin
            state_d = S_EX;
          end else begin
            illegal = 1'b1;
          end
        end
        S_EX: begin
          alu_op    = ex_alu_op;
          alu_src_b = ex_alu_src_b;
          ext_op    = ex_ext_op;
          if (is_beq) begin
            cmp_op     = CMP_BEQ;
            pc_sel     = 2'd1;
            pc_we      = branch;
            instr_done = 1'b1;
            state_d    = S_IF;
          end else if (is_lw || is_sw) begin
            state_d = S_MEM;
          end else if (is_legal_ex) begin
            state_d = S_WB;
          end else begin
            state_d = S_IF;
          end
        end
        S_MEM: begin
          alu_op       = ex_alu_op;
          alu_src_b    = ex_alu_src_b;
          ext_op       = ex_ext_op;
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = is_sw;
          if (mem_ready) begin
            if (is_sw) begin
              instr_done = 1'b1;
              state_d    = S_IF;
            end else begin
              state_d = S_WB;
            end
          end
        end
        S_WB: begin
          alu_op     = ex_alu_op;
          alu_src_b  = ex_alu_src_b;
          ext_op     = ex_ext_op;
          reg_we     = 1'b1;
          reg_dst    = is_addu | is_subu;
          wd_sel     = is_lw;
          instr_done = 1'b1;
          state_d    = S_IF;
        end
        default: state_d = S_IF;
      endcase
    end
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

- Multi-cycle control FSM for the MIPS subset `addu`, `subu`, `ori`, `lui`, `lw`, `sw`, `beq`, `j` and `nop`.
- Sequences each instruction through fetch, decode, execute, memory and write-back.
- Drives the ALU's operation and compare selects, and consumes the ALU's branch flag.
- Handshakes with a single shared instruction/data memory through `mem_req`/`mem_ready`.

## Interface
- `ALU_OP_W`, default 4: width of `alu_op`. Encodings: ADD=0, SUB=1, OR=2, LUI=3.
- `CMP_OP_W`, default 4: width of `cmp_op`. Encodings: NONE=0, BEQ=1.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr`  in  32  current IR contents; IR is loaded by `ir_we`.
- `branch`  in  1  ALU compare result; valid while `cmp_op`=BEQ.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request active.
- `mem_we`  out  1  request is a store.
- `mem_addr_sel`  out  1  0 = PC, 1 = ALU result.
- `ir_we`  out  1  load IR (and MDR) from memory read data.
- `pc_we`  out  1  update PC.
- `pc_sel`  out  2  0 = PC+4, 1 = branch target, 2 = jump target.
- `reg_we`  out  1  register-file write.
- `reg_dst`  out  1  0 = rt, 1 = rd.
- `wd_sel`  out  1  0 = ALU result, 1 = MDR.
- `alu_src_b`  out  1  0 = rt data, 1 = extended immediate.
- `ext_op`  out  1  0 = zero-extend, 1 = sign-extend.
- `alu_op`  out  ALU_OP_W  ALU operation select.
- `cmp_op`  out  CMP_OP_W  compare select.
- `instr_done`  out  1  one-cycle pulse when an instruction retires.
- `illegal`  out  1  one-cycle pulse on an undecodable instruction.

## Operation
- **Decode fields**
  - op = `instr[31:26]`, funct = `instr[5:0]`.
  - R-type (op 0x00): `addu` is funct 0x21, `subu` is funct 0x23.
  - I-type: `ori` 0x0D, `lui` 0x0F, `lw` 0x23, `sw` 0x2B, `beq` 0x04.
  - J-type: `j` 0x02.
  - `nop` is `instr` equal to 32'h0.
  - Anything else is illegal.
- **States:** IF, ID, EX, MEM, WB. The state register is the only storage; outputs are combinational from state, `instr`, `branch` and `mem_ready`.
- **Default output value:** 0 for every output not listed under a state.
- **IF**
  - Outputs: `mem_req`=1, `mem_addr_sel`=0.
  - On `mem_ready`=1: assert `ir_we`=1 and `pc_we`=1 with `pc_sel`=0, then go to ID. Otherwise stay in IF.
- **ID**
  - `j`: `pc_we`=1, `pc_sel`=2, `instr_done`=1, go to IF.
  - `nop`: `instr_done`=1, go to IF.
  - Illegal: `illegal`=1, go to IF. No `instr_done`; PC has already advanced past the instruction.
  - Any other instruction: go to EX.
- **EX**
  - `addu`: `alu_op`=ADD, `alu_src_b`=0, go to WB.
  - `subu`: `alu_op`=SUB, `alu_src_b`=0, go to WB.
  - `ori`: `alu_op`=OR, `alu_src_b`=1, `ext_op`=0, go to WB.
  - `lui`: `alu_op`=LUI, `alu_src_b`=1, `ext_op`=0, go to WB.
  - `lw`/`sw`: `alu_op`=ADD, `alu_src_b`=1, `ext_op`=1, go to MEM.
  - `beq`:
    - Outputs: `cmp_op`=BEQ, `alu_src_b`=0, `pc_sel`=1, `pc_we`=`branch`, `instr_done`=1.
    - Go to IF.
    - The datapath forms the target from the already-incremented PC.
- **MEM**
  - Hold the EX ALU controls.
  - Outputs: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=1 for `sw`.
  - Stay in MEM until `mem_ready`.
  - On `mem_ready` for `lw`: `ir_we` stays 0 (the datapath latches MDR on `mem_ready` with `mem_addr_sel`=1), go to WB.
  - On `mem_ready` for `sw`: `instr_done`=1, go to IF.
- **WB**
  - Hold the EX ALU controls.
  - Outputs: `reg_we`=1, `reg_dst`=1 for R-type, `wd_sel`=1 for `lw`, `instr_done`=1.
  - Go to IF.
- **Hold behaviour:** `alu_op`, `alu_src_b` and `ext_op` stay constant from EX through WB for the same instruction.
- **Exclusivity:** `cmp_op` is BEQ only in EX of a `beq`. `mem_we` is never 1 without `mem_req`.

## Timing
- **Reset**
  - `rst_n` low forces state to IF asynchronously and forces every output to 0, including `mem_req`.
  - The first fetch request appears in the first cycle with `rst_n` high.
- **Reset mid-operation:** from any state, return to IF. Any outstanding memory request is abandoned and no `reg_we`/`pc_we` is issued. `mem_ready` while `rst_n` is low is ignored.
- **Latency with zero-wait memory** (cycles from IF entry to `instr_done`, inclusive):
  - `addu`/`subu`/`ori`/`lui`: 4.
  - `sw`: 4.
  - `lw`: 5.
  - `beq`: 3.
  - `j`/`nop`: 2.
  - Illegal: 2, with `illegal` in place of `instr_done`.
- **Wait states:** each cycle `mem_ready`=0 in IF or MEM adds one cycle. Outputs remain stable while waiting.
- **`mem_ready` outside a request:** 1 while `mem_req`=0 has no effect.
- **Retire pulse:** `instr_done` pulses exactly once per retired instruction and is never asserted two cycles in a row.

## Test plan
- **Reset and first fetch:** hold `rst_n`=0 for 3 cycles with `mem_ready`=1 → all outputs 0. Release → cycle 1 shows `mem_req`=1, `mem_addr_sel`=0, `ir_we`=1, `pc_we`=1.
- **`addu` with zero-wait memory:** `instr`=32'h00221821 (`addu $3,$1,$2`), `mem_ready`=1 → EX `alu_op`=0, `alu_src_b`=0. WB has `reg_we`=1, `reg_dst`=1, `wd_sel`=0, `instr_done`=1. Total 4 cycles.
- **`lw` with memory waits:**
  - Stimulus: `lw` (32'h8C220004), `mem_ready` low for 2 cycles in IF and 3 cycles in MEM.
  - IF takes 3 cycles and MEM takes 4 cycles, with `mem_addr_sel`=1 and `mem_we`=0 throughout.
  - WB has `wd_sel`=1, `reg_dst`=0.
  - Total 10 cycles.
- **`beq` taken and not taken:** 32'h10220003 with `branch`=1 → EX `pc_we`=1, `pc_sel`=1, `cmp_op`=1. With `branch`=0 → `pc_we`=0. Both retire in 3 cycles.
- **`j`, `nop` and illegal opcode:**
  - `j` (32'h08000010) → ID `pc_sel`=2, `pc_we`=1, `instr_done`=1.
  - 32'h0 → only `instr_done` in ID.
  - 32'hFC000000 → `illegal`=1, no `instr_done`, next cycle is IF.
- **Reset mid-`sw`:** `sw` (32'hAC220008) stalled in MEM (`mem_req`=1, `mem_we`=1), drop `rst_n` → `mem_req` and `mem_we` fall with no clock edge required. After release the FSM is in IF and no `instr_done` fires for the `sw`.
